// File: rtl/ppu_pkg.sv
// Types and constants shared by the entity table and the PPU.
// The PPU slices entity words with the same field positions.
package ppu_pkg;
  localparam int ENTITY_W   = 18;
  localparam int ID_MSB     = 17;
  localparam int ID_LSB     = 14;
  localparam int ORIENT_MSB = 13;
  localparam int ORIENT_LSB = 12;
  localparam int POS_X_MSB  = 11;
  localparam int POS_X_LSB  = 8;
  localparam int POS_Y_MSB  = 7;
  localparam int POS_Y_LSB  = 4;
  localparam int FLIP_BIT   = 3;
  localparam int COUNT_MSB  = 2;
  localparam int COUNT_LSB  = 0;

  // ID 4'hF marks an unused slot, orientation 2'b11.
  localparam logic [ENTITY_W-1:0] EMPTY_ENTITY = 18'h3F000;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_MOVE   = 2'b10,
    OP_COMMIT = 2'b11
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;
endpackage

// File: rtl/entity_table_if.sv
// Valid/ready command port from game logic into the entity table.
interface entity_table_if;
  import ppu_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [3:0]          cmd_slot;
  logic [ENTITY_W-1:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_slot, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_slot, cmd_data, output cmd_ready);
endinterface

// File: rtl/entity_table.sv
// Double-buffered entity slots: commands edit a shadow bank, COMMIT copies it
// to the active bank (which drives the PPU) at the next frame boundary.
module entity_table
  import ppu_pkg::*;
#(
  parameter int NUM_SLOTS   = 15,
  parameter int VBLANK_LINE = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  entity_table_if.slave                 cmd,
  input  logic [9:0]                    counter_V,
  output logic [NUM_SLOTS*ENTITY_W-1:0] entities_flat,
  output logic                          commit_pending,
  output logic                          cmd_err
);
  typedef logic [NUM_SLOTS-1:0][ENTITY_W-1:0] bank_t;

  localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);
  localparam logic [9:0] BND_LINE  = 10'(VBLANK_LINE);

  bank_t      shadow_q, shadow_d;
  bank_t      active_q, active_d;
  state_e     state_q, state_d;
  logic [9:0] prev_v_q, prev_v_d;
  logic       err_q, err_d;
  logic       bnd, accept;

  // Rising edge of "counter_V at VBLANK_LINE": one cycle per frame.
  assign bnd    = (counter_V == BND_LINE) && (prev_v_q != BND_LINE);
  assign accept = cmd.cmd_valid && cmd.cmd_ready;

  assign cmd.cmd_ready  = reset && (state_q == ST_IDLE);
  assign commit_pending = reset && (state_q == ST_PENDING);
  assign cmd_err        = err_q;
  assign entities_flat  = active_q;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    state_d  = state_q;
    prev_v_d = counter_V;
    err_d    = 1'b0;

    if (accept) begin
      if (cmd_op_e'(cmd.cmd_op) == OP_COMMIT) begin
        state_d = ST_PENDING;
      end else if (cmd.cmd_slot > LAST_SLOT) begin
        err_d = 1'b1;
      end else begin
        case (cmd_op_e'(cmd.cmd_op))
          OP_WRITE: shadow_d[cmd.cmd_slot] = cmd.cmd_data;
          OP_CLEAR: shadow_d[cmd.cmd_slot] = EMPTY_ENTITY;
          OP_MOVE:  shadow_d[cmd.cmd_slot][POS_X_MSB:POS_Y_LSB] =
                      cmd.cmd_data[POS_X_MSB:POS_Y_LSB];
          OP_COMMIT: ;
        endcase
      end
    end

    // Only a commit already pending when bnd arrives uses that boundary.
    if (state_q == ST_PENDING && bnd) begin
      active_d = shadow_q;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q <= {NUM_SLOTS{EMPTY_ENTITY}};
      active_q <= {NUM_SLOTS{EMPTY_ENTITY}};
      state_q  <= ST_IDLE;
      prev_v_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      state_q  <= state_d;
      prev_v_q <= prev_v_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_entity_table.sv
// Scoreboard bench for entity_table: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_entity_table;
  import ppu_pkg::*;

  localparam int NS = 15;
  localparam int K_SLOT = 0, K_READY = 1, K_PEND = 2, K_ERR = 3;

  typedef struct {
    string       name;
    int          kind;
    int          slot;
    logic [17:0] exp;
  } chk_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [9:0]         cv;
  logic [NS*18-1:0]   ent_flat;
  logic               pend, err;
  int                 n_chk = 0;
  int                 n_fail = 0;
  chk_t               sb[$];

  entity_table_if bus();

  entity_table #(.NUM_SLOTS(NS), .VBLANK_LINE(480)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd           (bus.slave),
    .counter_V     (cv),
    .entities_flat (ent_flat),
    .commit_pending(pend),
    .cmd_err       (err)
  );

  always #20 clk = ~clk;

  function automatic void chk(string name, int kind, int slot, logic [17:0] exp);
    chk_t c;
    c.name = name; c.kind = kind; c.slot = slot; c.exp = exp;
    sb.push_back(c);
  endfunction

  // Monitor: compares every queued expectation at the next falling edge.
  initial begin
    chk_t        c;
    logic [17:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        c = sb.pop_front();
        case (c.kind)
          K_SLOT:  act = ent_flat[c.slot*18 +: 18];
          K_READY: act = {17'd0, bus.cmd_ready};
          K_PEND:  act = {17'd0, pend};
          default: act = {17'd0, err};
        endcase
        n_chk++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and returns 1 ns after the accepting edge.
  task automatic send(cmd_op_e op, logic [3:0] slot, logic [17:0] data);
    int waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_slot  = slot;
    bus.cmd_data  = data;
    while (bus.cmd_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: cmd_ready never 1, op %0d slot %0d", op, slot);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic boundary();
    cv = 10'd479; tick();
    cv = 10'd480; tick();
    cv = 10'd0;   tick();
  endtask

  task automatic all_empty(string name);
    for (int s = 0; s < NS; s++) chk(name, K_SLOT, s, EMPTY_ENTITY);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cv    = 10'd0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_slot  = 4'd0;
    bus.cmd_data  = '0;

    // Reset
    tick(); tick(); tick();
    all_empty("reset_slot");
    chk("reset_ready", K_READY, 0, 18'd0);
    chk("reset_pend",  K_PEND,  0, 18'd0);
    chk("reset_err",   K_ERR,   0, 18'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("post_reset_ready", K_READY, 0, 18'd1);
    chk("post_reset_pend",  K_PEND,  0, 18'd0);

    // Write without commit never reaches the output
    send(OP_WRITE, 4'd0, 18'h12345);
    boundary();
    chk("nocommit_slot0", K_SLOT, 0, 18'h3F000);

    // Commit and boundary
    send(OP_COMMIT, 4'd9, 18'h0);
    chk("commit_pend",  K_PEND,  0, 18'd1);
    chk("commit_ready", K_READY, 0, 18'd0);
    cv = 10'd479; tick();
    chk("pre_bnd_pend",  K_PEND, 0, 18'd1);
    chk("pre_bnd_slot0", K_SLOT, 0, 18'h3F000);
    cv = 10'd480;
    #1 chk("at_bnd_pend", K_PEND, 0, 18'd1);
    tick();
    chk("swap_slot0", K_SLOT,  0, 18'h12345);
    chk("swap_pend",  K_PEND,  0, 18'd0);
    chk("swap_ready", K_READY, 0, 18'd1);
    cv = 10'd0; tick();

    // Move copies only [11:4]
    send(OP_MOVE, 4'd0, 18'h2A7CB);
    send(OP_COMMIT, 4'd0, 18'h0);
    boundary();
    chk("move_slot0", K_SLOT, 0, 18'h127C5);
    chk("move_slot1", K_SLOT, 1, 18'h3F000);

    // Invalid slot
    send(OP_WRITE, 4'd15, 18'h00001);
    chk("inv_err_hi", K_ERR, 0, 18'd1);
    tick();
    chk("inv_err_lo",  K_ERR,  0, 18'd0);
    chk("inv_slot0",   K_SLOT, 0, 18'h127C5);
    chk("inv_slot14",  K_SLOT, 14, 18'h3F000);

    // Last write wins, clear, and slot 14 upper boundary
    send(OP_WRITE, 4'd3, 18'h0AAAA);
    send(OP_WRITE, 4'd3, 18'h15555);
    send(OP_CLEAR, 4'd0, 18'h12345);
    send(OP_WRITE, 4'd14, 18'h00E0E);
    chk("valid_err_lo", K_ERR, 0, 18'd0);
    send(OP_COMMIT, 4'd0, 18'h0);
    boundary();
    chk("last_wins_slot3", K_SLOT, 3,  18'h15555);
    chk("clear_slot0",     K_SLOT, 0,  18'h3F000);
    chk("write_slot14",    K_SLOT, 14, 18'h00E0E);

    // Commit accepted on the boundary cycle waits a frame
    send(OP_WRITE, 4'd1, 18'h00111);
    cv = 10'd479; tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_COMMIT;
    cv = 10'd480;
    tick();
    bus.cmd_valid = 1'b0;
    chk("samebnd_slot1", K_SLOT, 1, 18'h3F000);
    chk("samebnd_pend",  K_PEND, 0, 18'd1);
    cv = 10'd481; tick();
    cv = 10'd0;   tick();
    chk("samebnd_hold", K_SLOT, 1, 18'h3F000);
    boundary();
    chk("nextbnd_slot1", K_SLOT, 1, 18'h00111);
    chk("nextbnd_pend",  K_PEND, 0, 18'd0);

    // Reset while pending
    send(OP_WRITE, 4'd2, 18'h00222);
    send(OP_COMMIT, 4'd0, 18'h0);
    chk("rst_pend_before", K_PEND, 0, 18'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    all_empty("rst_pend_slot");
    chk("rst_pend_pend",  K_PEND,  0, 18'd0);
    chk("rst_pend_ready", K_READY, 0, 18'd0);
    @(negedge clk);
    reset = 1'b1;
    boundary();
    chk("rst_discard_slot2", K_SLOT, 2, 18'h3F000);
    chk("rst_discard_pend",  K_PEND, 0, 18'd0);

    tick(); tick();
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/entity_table.md
Name: entity_table

Overview:
- Producer end of the entity-slot interface that feeds the picture processing unit.
- Game logic writes, clears and moves entities through a valid/ready command port into a shadow bank.
- A COMMIT command copies the shadow bank into the active bank at the next frame boundary, so the PPU never sees a half-updated scene.
- The active bank drives the PPU's 15 entity slot inputs.

Parameters:
- NUM_SLOTS, 15, number of entity slots.
- ENTITY_W, 18, entity word width: [17:14] ID, [13:12] orientation, [11:8] tile X, [7:4] tile Y, [3] vertical flip, [2:0] tile count.
- VBLANK_LINE, 480, counter_V value that marks the frame boundary.

Ports:
- clk  in  1  pixel clock, 25 MHz.
- reset  in  1  synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 WRITE, 01 CLEAR, 10 MOVE, 11 COMMIT.
- cmd_slot  in  4  target slot, 0..NUM_SLOTS-1. Ignored for COMMIT.
- cmd_data  in  ENTITY_W  entity word. WRITE uses all bits; MOVE uses [11:4].
- counter_V  in  10  vertical pixel counter from the VGA timing block.
- entities_flat  out  NUM_SLOTS*ENTITY_W  active bank. Slot k is at [ENTITY_W*k+17 : ENTITY_W*k]. Slot 0 drives entity_1.
- commit_pending  out  1  a COMMIT is waiting for the frame boundary.
- cmd_err  out  1  one-cycle pulse when a command is rejected for an invalid slot.

Behaviour:
- Reset is synchronous, active-low (reset=0 resets), clock clk.
- While reset=0:
  - every shadow and active slot is loaded with EMPTY = 18'h3F000 (ID 4'hF = unused, orientation 2'b11);
  - state = IDLE, commit_pending=0, cmd_err=0, prev_V=0;
  - cmd_ready=0.
- Reset asserted mid-PENDING discards the pending commit. The active bank returns to EMPTY immediately, not at the next boundary.
- Frame boundary: bnd = (counter_V == VBLANK_LINE) && (prev_V != VBLANK_LINE). prev_V is counter_V registered every cycle. bnd is therefore true for exactly one cycle per frame.
- State machine, two states:
  - IDLE: cmd_ready=1.
  - PENDING: cmd_ready=0, commit_pending=1.
- Transitions:
  - IDLE -> PENDING when a COMMIT is accepted.
  - PENDING -> IDLE on the clock edge where bnd=1. On that edge the active bank takes all shadow slots in one parallel copy.
  - entities_flat shows the new scene from the cycle after that edge.
- A COMMIT accepted on the same cycle as bnd does not use that boundary. It waits for the next bnd, about one frame later.
- Command effects, shadow bank only, applied on the accepting edge (visible in the shadow one cycle later):
  - WRITE: shadow[slot] <= cmd_data.
  - CLEAR: shadow[slot] <= EMPTY.
  - MOVE: shadow[slot][11:4] <= cmd_data[11:4]; all other bits keep their value.
  - COMMIT: no shadow change. Accepted whatever cmd_slot holds; never raises cmd_err.
- Invalid slot, cmd_slot >= NUM_SLOTS, on WRITE, CLEAR or MOVE:
  - the command is still accepted (handshake completes);
  - no bank changes;
  - cmd_err=1 on the following cycle only.
- With no COMMIT, shadow edits never reach entities_flat.
- Width rule: MOVE does not clamp or wrap the location; it is a plain field copy.
- Multiple WRITE/MOVE commands to the same slot before a COMMIT: the last one wins.
- entities_flat is a registered output. It holds its value between commits, with no glitches.

Decomposition:
- Shared package ppu_pkg holds:
  - ENTITY_W and field bit positions (ID, ORIENT, POS_X, POS_Y, FLIP, COUNT);
  - EMPTY_ENTITY = 18'h3F000;
  - op-code constants OP_WRITE, OP_CLEAR, OP_MOVE, OP_COMMIT;
  - state encoding ST_IDLE, ST_PENDING.
- The PPU uses the same package for its field slicing.
- No sub-module. The boundary edge detector and the two-bank register array are kept inline.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release.
  -> All 15 slots of entities_flat = 18'h3F000, cmd_ready=0 during reset and 1 after, commit_pending=0.
- Write without commit: WRITE slot 0 with 18'h12345, then run a full frame.
  -> Slot 0 output stays 18'h3F000.
- Commit: COMMIT, then sweep counter_V 479 -> 480.
  -> commit_pending=1 and cmd_ready=0 until the 480 edge.
  -> Slot 0 = 18'h12345 the cycle after that edge; commit_pending=0 and cmd_ready=1.
- Move: MOVE slot 0 with cmd_data[11:4]=8'h7C, then COMMIT and a boundary.
  -> Slot 0 = 18'h127C5; other slots unchanged.
- Invalid slot: WRITE slot 15 with 18'h00001.
  -> Accepted, cmd_err high for exactly 1 cycle, no bank change.
- Edge cases:
  - COMMIT accepted on the same cycle counter_V first reaches 480 -> no swap at that boundary; swap at the next one.
  - Reset asserted while PENDING -> all slots = 18'h3F000, commit_pending=0.
